// File: rtl/lns_fmadd_pipe.sv
// lns_fmadd_pipe: 3-stage log-number-system fused multiply-add with valid/ready flow control.
// Define LNS_FMADD_SAT_FLAG_EN to add the out_sat saturation/underflow flag output.
module lns_fmadd_pipe #(
  parameter int LOG_W = 11,
  parameter int FRAC_W = 7,
  parameter int D_INT = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [1:0] op,
  input  logic [LOG_W:0] a,
  input  logic [LOG_W:0] b,
  input  logic [LOG_W:0] c,
  output logic out_valid,
  input  logic out_ready,
  output logic [LOG_W:0] out
`ifdef LNS_FMADD_SAT_FLAG_EN
  ,
  output logic out_sat
`endif
);
  localparam int DW = LOG_W + 1;
  localparam logic signed [LOG_W-1:0] ZL = {1'b1, {(LOG_W-1){1'b0}}};
  localparam logic signed [LOG_W-1:0] ML = {1'b0, {(LOG_W-1){1'b1}}};
  localparam logic signed [LOG_W+1:0] HI = (LOG_W+2)'(ML);
  localparam logic signed [LOG_W+1:0] LO = (LOG_W+2)'(ZL);
  function automatic logic signed [LOG_W:0] gl(input int d, input logic sub);
    real x, v;
    x = $pow(2.0, -real'(d) / real'(2 ** FRAC_W));
    v = real'(2 ** FRAC_W) * $ln(sub ? 1.0 - x : 1.0 + x) / $ln(2.0);
    return (sub && d == 0) || d >= D_INT * 2 ** FRAC_W ? '0 : (LOG_W+1)'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
  endfunction
  // Tables span every possible distance so the lookup needs no range guard.
  logic signed [LOG_W:0] sb_rom [2**DW];
  logic signed [LOG_W:0] db_rom [2**DW];
  for (genvar i = 0; i < 2**DW; i++) begin : g_rom
    assign sb_rom[i] = gl(i, 1'b0);
    assign db_rom[i] = gl(i, 1'b1);
  end
  logic en, v1, v2, zab, ovf, unf, r_ovf, r_unf, pbig, byp, s2, sub2, byp2, cancel;
  logic [LOG_W:0] p1, c1, d2;
  logic signed [LOG_W+1:0] sum, r;
  logic signed [LOG_W:0] dif, t;
  logic signed [LOG_W-1:0] lp, lc, l2;
  logic [LOG_W-1:0] rl;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  always_comb begin
    zab = a[LOG_W-1:0] == ZL || b[LOG_W-1:0] == ZL;
    sum = (LOG_W+2)'($signed(a[LOG_W-1:0])) + (LOG_W+2)'($signed(b[LOG_W-1:0]));
    ovf = !zab && sum > HI;
    unf = !zab && sum <= LO;
  end
  always_ff @(posedge clk)
    if (rst) v1 <= 1'b0;
    else if (en) begin
      v1 <= in_valid;
      p1 <= op == 2'b10 ? a : {a[LOG_W] ^ b[LOG_W], zab || unf ? ZL : ovf ? ML : sum[LOG_W-1:0]};
      c1 <= op == 2'b01 ? {1'b0, ZL} : {c[LOG_W] ^ (op == 2'b11), c[LOG_W-1:0]};
    end
  // ZERO is the smallest log, so the larger operand is always the non-zero one on bypass.
  always_comb begin
    lp = p1[LOG_W-1:0];
    lc = c1[LOG_W-1:0];
    pbig = lp >= lc;
    byp = lp == ZL || lc == ZL;
    dif = (LOG_W+1)'(lp) - (LOG_W+1)'(lc);
  end
  always_ff @(posedge clk)
    if (rst) v2 <= 1'b0;
    else if (en) begin
      v2 <= v1;
      s2 <= pbig ? p1[LOG_W] : c1[LOG_W];
      l2 <= pbig ? lp : lc;
      d2 <= pbig ? dif : -dif;
      sub2 <= p1[LOG_W] != c1[LOG_W] && !byp;
      byp2 <= byp;
    end
  always_comb begin
    t = byp2 ? '0 : sub2 ? db_rom[d2] : sb_rom[d2];
    r = (LOG_W+2)'(l2) + (LOG_W+2)'(t);
    cancel = sub2 && d2 == '0;
    r_ovf = !byp2 && r > HI;
    r_unf = !byp2 && !cancel && r <= LO;
    rl = cancel || r_unf ? ZL : r_ovf ? ML : r[LOG_W-1:0];
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out <= {1'b0, ZL};
    end else if (en) begin
      out_valid <= v2;
      out <= {s2 && rl != ZL, rl};
    end
`ifdef LNS_FMADD_SAT_FLAG_EN
  logic sat1, sat2;
  always_ff @(posedge clk)
    if (rst) out_sat <= 1'b0;
    else if (en) begin
      sat1 <= op != 2'b10 && (ovf || unf);
      sat2 <= sat1;
      out_sat <= sat2 || r_ovf || r_unf;
    end
`endif
endmodule
